park_entry_encrypt: RTL and testbench

//  Entry-side counterpart of the parking-lot exit decrypter. On a car entry request it

---
 rtl/park_entry_encrypt_if.sv | 29 ++
 rtl/park_entry_encrypt.sv | 121 ++++++++++++
 tb/tb_park_entry_encrypt.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/park_entry_encrypt_if.sv
// Parking-lot entry/exit bus: the entry request and token handshake, the exit
// check, and the occupancy status outputs. Clock and reset stay as plain ports.
interface park_entry_encrypt_if #(
    parameter int ID_W = 3
);
    logic            enter;
    logic [ID_W-1:0] pattern;
    logic [ID_W-1:0] token;
    logic            token_valid;
    logic            token_ack;
    logic            reject;
    logic            exit;
    logic [ID_W-1:0] exit_token;
    logic            exit_err;
    logic            full;
    logic [ID_W:0]   count;

    // Gate controller / ticket printer side.
    modport master (
        output enter, pattern, token_ack, exit, exit_token,
        input  token, token_valid, reject, exit_err, full, count
    );

    // Slot allocator side.
    modport slave (
        input  enter, pattern, token_ack, exit, exit_token,
        output token, token_valid, reject, exit_err, full, count
    );
endinterface

// File: rtl/park_entry_encrypt.sv
// Parking-lot entry encrypter. An entry request allocates the lowest free slot
// and issues token = slot ^ pattern under a valid/ack handshake. Exit requests
// are decrypted with the same pattern and free the named slot, or raise
// exit_err for one cycle when the slot is free or does not exist.
module park_entry_encrypt #(
    parameter int NUM_SLOTS = 8,
    parameter int ID_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    park_entry_encrypt_if.slave   bus
);

    localparam logic [ID_W:0] FULL_COUNT = (ID_W + 1)'(NUM_SLOTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t                 state;
    logic [NUM_SLOTS-1:0]   occ;
    logic [ID_W-1:0]        token_q;
    logic                   token_valid_q;
    logic                   reject_q;
    logic                   exit_err_q;
    logic [ID_W:0]          count_q;
    logic                   full_q;

    logic [ID_W-1:0]        free_slot;
    logic [ID_W-1:0]        exit_slot;
    logic [NUM_SLOTS-1:0]   set_mask;
    logic [NUM_SLOTS-1:0]   clr_mask;
    logic                   do_alloc;
    logic                   exit_ok;
    logic [ID_W:0]          count_next;

    // Lowest free slot, taken from the registered (pre-exit) bitmap.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ[i]) free_slot = ID_W'(i);
        end
    end

    // Set/clear masks for this cycle's allocation and exit; they never overlap
    // because the allocated slot is free and a valid exit slot is occupied.
    always_comb begin
        exit_slot = bus.exit_token ^ bus.pattern;
        do_alloc  = (state == ALLOC);
        set_mask  = '0;
        clr_mask  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            set_mask[i] = do_alloc && (free_slot == ID_W'(i));
            clr_mask[i] = bus.exit && occ[i] && (exit_slot == ID_W'(i));
        end
        exit_ok = |clr_mask;
    end

    // Occupancy count after this cycle; simultaneous alloc and exit cancel out.
    always_comb begin
        count_next = count_q;
        unique case ({do_alloc, exit_ok})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    // Entry FSM plus bitmap, count and all registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            occ           <= '0;
            token_q       <= '0;
            token_valid_q <= 1'b0;
            reject_q      <= 1'b0;
            exit_err_q    <= 1'b0;
            count_q       <= '0;
            full_q        <= 1'b0;
        end else begin
            occ        <= (occ | set_mask) & ~clr_mask;
            count_q    <= count_next;
            full_q     <= (count_next == FULL_COUNT);
            exit_err_q <= bus.exit && !exit_ok;
            reject_q   <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.enter) begin
                        if (full_q) reject_q <= 1'b1;
                        else        state    <= ALLOC;
                    end
                end
                ALLOC: begin
                    token_q       <= free_slot ^ bus.pattern;
                    token_valid_q <= 1'b1;
                    state         <= ISSUE;
                end
                ISSUE: begin
                    if (bus.token_ack) begin
                        token_valid_q <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.token       = token_q;
    assign bus.token_valid = token_valid_q;
    assign bus.reject      = reject_q;
    assign bus.exit_err    = exit_err_q;
    assign bus.count       = count_q;
    assign bus.full        = full_q;

endmodule

// File: tb/tb_park_entry_encrypt.sv
// Self-checking bench for park_entry_encrypt: directed scenarios followed by a
// randomized mix of entries, exits and pattern changes, checked against a
// slot-array model of the parking lot.
module tb_park_entry_encrypt;

    localparam int NUM_SLOTS = 8;
    localparam int ID_W      = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    park_entry_encrypt_if #(.ID_W(ID_W)) bus ();

    park_entry_encrypt #(
        .NUM_SLOTS(NUM_SLOTS),
        .ID_W     (ID_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: which slots hold a car.
    bit ref_occ [NUM_SLOTS];

    function automatic int ref_count();
        int n = 0;
        for (int i = 0; i < NUM_SLOTS; i++) n += int'(ref_occ[i]);
        return n;
    endfunction

    function automatic int ref_lowest_free();
        for (int i = 0; i < NUM_SLOTS; i++) if (!ref_occ[i]) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, 32'(bus.count), 32'(ref_count()));
        check({tag, "_full"},  32'(bus.full),  32'(ref_count() == NUM_SLOTS));
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_SLOTS; i++) ref_occ[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One entry request; optionally presents an exit in the ALLOC cycle and
    // holds the token for ack_wait cycles before acknowledging it.
    task automatic entry(input int ack_wait, input bit ex_in_alloc, input logic [ID_W-1:0] ex_tok);
        int slot;
        int e;
        bit ex_hit;
        bit was_full;
        logic [31:0] exp_tok;
        was_full  = (ref_count() == NUM_SLOTS);
        bus.enter = 1'b1;
        @(negedge clk);
        bus.enter = 1'b0;
        if (was_full) begin
            check("reject_set",   32'(bus.reject),      32'(1));
            check("reject_noval", 32'(bus.token_valid), 32'(0));
            @(negedge clk);
            check("reject_pulse", 32'(bus.reject),      32'(0));
            check("reject_noval2", 32'(bus.token_valid), 32'(0));
            check_status("reject");
            return;
        end
        check("no_reject",  32'(bus.reject),      32'(0));
        check("alloc_noval", 32'(bus.token_valid), 32'(0));
        slot = ref_lowest_free();
        if (ex_in_alloc) begin
            bus.exit       = 1'b1;
            bus.exit_token = ex_tok;
        end
        @(negedge clk);
        bus.exit = 1'b0;
        e      = int'(ex_tok ^ bus.pattern);
        ex_hit = ex_in_alloc && (e < NUM_SLOTS) && ref_occ[e];
        ref_occ[slot] = 1'b1;
        if (ex_hit) ref_occ[e] = 1'b0;
        exp_tok = 32'(slot) ^ 32'(bus.pattern);
        if (ex_in_alloc) check("alloc_exit_err", 32'(bus.exit_err), 32'(!ex_hit));
        check("token_valid", 32'(bus.token_valid), 32'(1));
        check("token",       32'(bus.token),       exp_tok);
        check_status("issue");
        for (int k = 0; k < ack_wait; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.token_valid), 32'(1));
            check("hold_token", 32'(bus.token),       exp_tok);
        end
        bus.token_ack = 1'b1;
        @(negedge clk);
        bus.token_ack = 1'b0;
        check("ack_drop", 32'(bus.token_valid), 32'(0));
    endtask

    // One exit request outside any allocation.
    task automatic exit_op(input logic [ID_W-1:0] tok);
        int e;
        bit hit;
        e   = int'(tok ^ bus.pattern);
        hit = (e < NUM_SLOTS) && ref_occ[e];
        bus.exit       = 1'b1;
        bus.exit_token = tok;
        @(negedge clk);
        bus.exit = 1'b0;
        if (hit) ref_occ[e] = 1'b0;
        check("exit_err", 32'(bus.exit_err), 32'(!hit));
        check_status("exit");
        @(negedge clk);
        check("exit_err_pulse", 32'(bus.exit_err), 32'(0));
    endtask

    initial begin
        bus.enter      = 1'b0;
        bus.pattern    = '0;
        bus.token_ack  = 1'b0;
        bus.exit       = 1'b0;
        bus.exit_token = '0;

        // Reset state.
        do_reset();
        check("rst_valid",  32'(bus.token_valid), 32'(0));
        check("rst_token",  32'(bus.token),       32'(0));
        check("rst_reject", 32'(bus.reject),      32'(0));
        check("rst_exerr",  32'(bus.exit_err),    32'(0));
        check_status("rst");

        // First entry with a non-zero pattern.
        bus.pattern = 3'b101;
        entry(1, 1'b0, '0);

        // Fill the lot with pattern 0, then one more request is rejected.
        do_reset();
        bus.pattern = '0;
        for (int i = 0; i < NUM_SLOTS; i++) entry(0, 1'b0, '0);
        check("filled_full", 32'(bus.full), 32'(1));
        entry(0, 1'b0, '0);

        // Free slot 3 under a new pattern; it is reallocated next.
        bus.pattern = 3'b110;
        exit_op(3'b101);
        entry(0, 1'b0, '0);

        // Bogus exit of a free slot, then exit of slot 0 during ALLOC.
        do_reset();
        bus.pattern = ID_W'($urandom);
        entry(0, 1'b0, '0);
        entry(0, 1'b0, '0);
        exit_op(3'd5 ^ bus.pattern);
        entry(2, 1'b1, 3'd0 ^ bus.pattern);
        entry(0, 1'b0, '0);

        // Asynchronous reset while a token is pending.
        bus.enter = 1'b1;
        @(negedge clk);
        bus.enter = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 32'(bus.token_valid), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(bus.token_valid), 32'(0));
        check("async_token", 32'(bus.token),       32'(0));
        check("async_count", 32'(bus.count),       32'(0));
        check("async_full",  32'(bus.full),        32'(0));
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        entry(0, 1'b0, '0);

        // Randomized mix against the model.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5)
                entry(int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), ID_W'($urandom));
            else if (r < 9)
                exit_op(ID_W'($urandom));
            else
                bus.pattern = ID_W'($urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
